svga_timing: RTL

Free-running SVGA raster timing generator for the note-recognizer display path. Produces the pixel coordinate pair (x, y), horizontal/vertical sync, display-enable and frame/line markers, one pixel per clock. It sits directly upstream of the per-pixel renderers (staff-line grid, note overlays), which consume x/y combinationally. Its sync outputs go to the VGA connector, aligned with the renderer colour outputs.

---
 rtl/svga_pkg.sv | 31 +++
 rtl/svga_axis_counter.sv | 57 +++++
 rtl/svga_timing.sv | 95 +++++++++
 3 files changed

// File: rtl/svga_pkg.sv
// Shared types and timing constants for the SVGA raster generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package svga_pkg;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} svga_phase_t;

    localparam int X_W = 12;
    localparam int Y_W = 11;

    // 800x600@60 with a 40 MHz pixel clock
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FRONT  = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BACK   = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FRONT  = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BACK   = 23;

    // Reduced raster for fast simulation
    localparam int SIM_H_ACTIVE = 16;
    localparam int SIM_H_FRONT  = 2;
    localparam int SIM_H_SYNC   = 4;
    localparam int SIM_H_BACK   = 2;
    localparam int SIM_V_ACTIVE = 8;
    localparam int SIM_V_FRONT  = 1;
    localparam int SIM_V_SYNC   = 2;
    localparam int SIM_V_BACK   = 1;

endpackage

// File: rtl/svga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Latency: count/phase registered; wrap is combinational from count and advance.
// Backpressure: none; steps whenever advance is high.
module svga_axis_counter
    import svga_pkg::*;
#(
    parameter int W      = 12,
    parameter int ACTIVE = 800,
    parameter int FRONT  = 40,
    parameter int SYNC   = 128,
    parameter int BACK   = 88
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic         advance,
    output logic [W-1:0] count,
    output svga_phase_t  phase,
    output logic         wrap
);

    localparam logic [W-1:0] END_ACTIVE = W'(ACTIVE - 1);
    localparam logic [W-1:0] END_FRONT  = W'(ACTIVE + FRONT - 1);
    localparam logic [W-1:0] END_SYNC   = W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [W-1:0] END_BACK   = W'(ACTIVE + FRONT + SYNC + BACK - 1);

    svga_phase_t phase_next;

    assign wrap = advance && (count == END_BACK);

    // Position and phase state; reset parks the axis at the first position.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else begin
            phase <= phase_next;
            if (advance) begin
                count <= wrap ? '0 : count + W'(1);
            end
        end
    end

    // Phase advances when the count sits on the last position of the current phase.
    always_comb begin
        phase_next = phase;
        if (advance) begin
            unique case (phase)
                PH_ACTIVE: if (count == END_ACTIVE) phase_next = PH_FRONT;
                PH_FRONT:  if (count == END_FRONT)  phase_next = PH_SYNC;
                PH_SYNC:   if (count == END_SYNC)   phase_next = PH_BACK;
                PH_BACK:   if (count == END_BACK)   phase_next = PH_ACTIVE;
                default:   phase_next = PH_ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/svga_timing.sv
// Free-running SVGA raster generator: x/y, syncs, display enable, line/frame pulses.
// Latency: all outputs registered and mutually aligned (describe the x/y of the same cycle).
// Backpressure: none; runs every clock.
module svga_timing
    import svga_pkg::*;
#(
    parameter bit   is_simulation = 1'b0,
    parameter int   H_ACTIVE      = SVGA_H_ACTIVE,
    parameter int   H_FRONT       = SVGA_H_FRONT,
    parameter int   H_SYNC        = SVGA_H_SYNC,
    parameter int   H_BACK        = SVGA_H_BACK,
    parameter int   V_ACTIVE      = SVGA_V_ACTIVE,
    parameter int   V_FRONT       = SVGA_V_FRONT,
    parameter int   V_SYNC        = SVGA_V_SYNC,
    parameter int   V_BACK        = SVGA_V_BACK,
    parameter logic SYNC_POL      = 1'b1
) (
    input  logic           clk,
    input  logic           reset_p,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic           line_start,
    output logic           frame_start
);

    localparam int HA = is_simulation ? SIM_H_ACTIVE : H_ACTIVE;
    localparam int HF = is_simulation ? SIM_H_FRONT  : H_FRONT;
    localparam int HS = is_simulation ? SIM_H_SYNC   : H_SYNC;
    localparam int HB = is_simulation ? SIM_H_BACK   : H_BACK;
    localparam int VA = is_simulation ? SIM_V_ACTIVE : V_ACTIVE;
    localparam int VF = is_simulation ? SIM_V_FRONT  : V_FRONT;
    localparam int VS = is_simulation ? SIM_V_SYNC   : V_SYNC;
    localparam int VB = is_simulation ? SIM_V_BACK   : V_BACK;

    localparam logic [X_W-1:0] X_LAST = X_W'(HA + HF + HS + HB - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(VA + VF + VS + VB - 1);

    // The axis counters run one clock ahead of the outputs: while the output
    // registers hold the last raster position during reset, the counters are
    // already parked at (0,0), so the first clock out of reset shows pixel 0.
    logic [X_W-1:0] h_count;
    logic [Y_W-1:0] v_count;
    svga_phase_t    h_phase;
    svga_phase_t    v_phase;
    logic           h_wrap;
    logic           v_wrap_unused;

    svga_axis_counter #(
        .W(X_W), .ACTIVE(HA), .FRONT(HF), .SYNC(HS), .BACK(HB)
    ) u_h_axis (
        .clk     (clk),
        .reset_p (reset_p),
        .advance (1'b1),
        .count   (h_count),
        .phase   (h_phase),
        .wrap    (h_wrap)
    );

    // Frame start is decoded from the ahead counters, so the vertical wrap is not consumed.
    svga_axis_counter #(
        .W(Y_W), .ACTIVE(VA), .FRONT(VF), .SYNC(VS), .BACK(VB)
    ) u_v_axis (
        .clk     (clk),
        .reset_p (reset_p),
        .advance (h_wrap),
        .count   (v_count),
        .phase   (v_phase),
        .wrap    (v_wrap_unused)
    );

    // Output registers: latch the ahead position and decode its flags together.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= h_count;
            y           <= v_count;
            hsync       <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            display_on  <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            line_start  <= (h_count == '0);
            frame_start <= (h_count == '0) && (v_count == '0);
        end
    end

endmodule
